// File: rtl/keccak_theta_inv.sv
// Recovers A from A' = theta(A) by walking the column-parity orbit one map step per clock (L cycles).
// One job in flight: in_ready low while busy; the result is held until out_ready.
module keccak_theta_inv #(
    parameter int W        = 8,
    parameter int b        = 200,
    parameter int MAX_ITER = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [b-1:0] In,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [b-1:0] Out,
    output logic         error
);

    localparam int PW = 5 * W;
    localparam int CW = $clog2(MAX_ITER) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_ITER - 1);

    typedef enum logic [1:0] {IDLE, ITER, OUT} state_t;

    function automatic logic [W-1:0] rotl1(input logic [W-1:0] v);
        return {v[W-2:0], v[W-1]};
    endfunction

    function automatic logic [PW-1:0] col_parity(input logic [b-1:0] s);
        logic [PW-1:0] p;
        p = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                p[x*W +: W] = p[x*W +: W] ^ s[(5*x+y)*W +: W];
        return p;
    endfunction

    // Effect of theta on the column parities (odd row count keeps each column's own term).
    function automatic logic [PW-1:0] parity_map(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        for (int x = 0; x < 5; x++)
            r[x*W +: W] = p[x*W +: W] ^ p[((x+4)%5)*W +: W] ^ rotl1(p[((x+1)%5)*W +: W]);
        return r;
    endfunction

    function automatic logic [b-1:0] undo_theta(input logic [b-1:0] s, input logic [PW-1:0] p);
        logic [b-1:0] r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[(5*x+y)*W +: W] = s[(5*x+y)*W +: W] ^ p[((x+4)%5)*W +: W]
                                    ^ rotl1(p[((x+1)%5)*W +: W]);
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [b-1:0]  a_q, a_d;
    logic [PW-1:0] pt_q, pt_d;
    logic [PW-1:0] cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [b-1:0]  out_q, out_d;
    logic          err_q, err_d;
    logic          vld_q, vld_d;
    logic [PW-1:0] nxt;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        pt_d    = pt_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = err_q;
        vld_d   = vld_q;
        nxt     = parity_map(cur_q);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = In;
                    pt_d    = col_parity(In);
                    cur_d   = col_parity(In);
                    cnt_d   = '0;
                    state_d = ITER;
                end
            end
            ITER: begin
                // cur is the predecessor of Pt on its orbit exactly when one more step closes the cycle.
                if (nxt == pt_q) begin
                    out_d   = undo_theta(a_q, cur_q);
                    err_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    out_d   = a_q;
                    err_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    cur_d = nxt;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            pt_q    <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            pt_q    <= pt_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = vld_q;
    assign Out       = out_q;
    assign error     = err_q;

endmodule
